// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map and FSM states.
package alu_pkg;

  // Opcode map, numerically identical to the original combinational ALU
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_INCR = 4'd3;
  localparam logic [3:0] OP_DECR = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_XNOR = 4'd11;
  localparam logic [3:0] OP_ARSH = 4'd12;
  localparam logic [3:0] OP_ALSH = 4'd13;
  localparam logic [3:0] OP_LRSH = 4'd14;
  localparam logic [3:0] OP_LLSH = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Multiply is the only opcode that takes the multi-cycle path
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// The accumulator holds {partial_high, remaining_multiplier_bits}; each step
// conditionally adds the multiplicand into the high half and shifts right.
// done and product are combinational from the final step so that the caller
// can capture the product on the same edge that completes the last iteration.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  // One shift-add iteration on the current accumulator
  always_comb begin
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
    last_step = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  // Load operands on start, otherwise iterate while busy
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start && !busy_q) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = last_step;
  assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle datapath for all ops except MUL,
// which is handed to the iterative multiplier while the FSM holds off
// new requests. Results sit in output registers until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_w, sub_w, inc_w, dec_w;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(opcode) && !mul_busy;

  assign shamt = operand2[SHW-1:0];
  assign add_w = {1'b0, operand1} + {1'b0, operand2};
  assign sub_w = {1'b0, operand1} - {1'b0, operand2};
  assign inc_w = {1'b0, operand1} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, operand1} - {{WIDTH{1'b0}}, 1'b1};

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (operand1),
    .b       (operand2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result for every non-multiply opcode; the top bit of the
  // widened subtract is the borrow
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (opcode)
      OP_ADD:  {op_carry, op_res} = add_w;
      OP_SUB:  {op_carry, op_res} = sub_w;
      OP_MUL:  op_res = '0;
      OP_INCR: {op_carry, op_res} = inc_w;
      OP_DECR: {op_carry, op_res} = dec_w;
      OP_AND:  op_res = operand1 & operand2;
      OP_OR:   op_res = operand1 | operand2;
      OP_NOT:  op_res = ~operand1;
      OP_NAND: op_res = ~(operand1 & operand2);
      OP_NOR:  op_res = ~(operand1 | operand2);
      OP_XOR:  op_res = operand1 ^ operand2;
      OP_XNOR: op_res = ~(operand1 ^ operand2);
      OP_ARSH: op_res = $unsigned($signed(operand1) >>> shamt);
      OP_ALSH: op_res = operand1 << shamt;
      OP_LRSH: op_res = operand1 >> shamt;
      OP_LLSH: op_res = operand1 << shamt;
    endcase
  end

  // Handshake FSM and result register next-state; results hold unless loaded
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul(opcode)) begin
            state_d = MUL;
          end else begin
            result_d    = op_res;
            result_hi_d = '0;
            carry_d     = op_carry;
            zero_d      = (op_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          zero_d      = (mul_product == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset wins over any concurrent transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule
